// File: rtl/instr_encoder_pkg.sv
// Shared control definitions for the MIPS add/sub instruction encoder and decoder:
// opcode/funct constants, request op codes and word-packing helpers.
package instr_encoder_pkg;

    localparam logic [5:0] OPCODE_R_type = 6'h00;
    localparam logic [5:0] OPCODE_ADDI   = 6'h08;
    localparam logic [5:0] OPCODE_ADDIU  = 6'h09;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    localparam logic [31:0] NOP_WORD  = '0;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ADDU  = 3'd1,
        OP_SUB   = 3'd2,
        OP_SUBU  = 3'd3,
        OP_ADDI  = 3'd4,
        OP_ADDIU = 3'd5,
        OP_ILL6  = 3'd6,
        OP_ILL7  = 3'd7
    } enc_op_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_PAD = 1'b1
    } enc_state_e;

    function automatic logic [31:0] pack_r(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {OPCODE_R_type, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] pack_i(
        input logic [5:0]  opcode,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: request op code and register/immediate fields
// to an encoded MIPS word, flagging op codes with no encoding.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    enc_op_e op_e;

    assign op_e = enc_op_e'(op);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_e)
            OP_ADD:   word = pack_r(rs, rt, rd, FUNCT_ADD);
            OP_ADDU:  word = pack_r(rs, rt, rd, FUNCT_ADDU);
            OP_SUB:   word = pack_r(rs, rt, rd, FUNCT_SUB);
            OP_SUBU:  word = pack_r(rs, rt, rd, FUNCT_SUBU);
            OP_ADDI:  word = pack_i(OPCODE_ADDI, rs, rt, imm);
            OP_ADDIU: word = pack_i(OPCODE_ADDIU, rs, rt, imm);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: one word per cycle into an instruction-memory writer.
// Define ENC_NOP_PAD_EN to append a NOP word after each request marked in_last.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [4:0]          in_rs,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_rd,
    input  logic [15:0]         in_imm,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_addr,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    enc_state_e            state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [31:0]           out_addr_q, out_addr_d;
    logic                  err_q, err_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

    logic [31:0]           pack_word;
    logic                  pack_illegal;
    logic                  accept;
    logic                  out_fire;

    instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign in_ready = !Reset && (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

`ifdef ENC_NOP_PAD_EN
    logic nop_loaded_q, nop_loaded_d;
`else
    logic unused_last;
    assign unused_last = in_last;
`endif

    // A handshake and a new acceptance in the same cycle reload the register in place.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
`ifdef ENC_NOP_PAD_EN
        nop_loaded_d = nop_loaded_q;
`endif

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q + ADDR_STEP;
        end

        if (accept) begin
            if (pack_illegal) begin
                err_d = 1'b1;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                out_valid_d = 1'b1;
                out_instr_d = pack_word;
            end
        end

`ifdef ENC_NOP_PAD_EN
        // The NOP is loaded once the final word has left (or was never produced).
        case (state_q)
            ST_RUN: begin
                if (accept && in_last) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (!nop_loaded_q) begin
                    if (!out_valid_q || out_ready) begin
                        out_valid_d  = 1'b1;
                        out_instr_d  = NOP_WORD;
                        nop_loaded_d = 1'b1;
                    end
                end else if (out_fire) begin
                    state_d      = ST_RUN;
                    nop_loaded_d = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
`else
        state_d = ST_RUN;
`endif
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef ENC_NOP_PAD_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            nop_loaded_q <= 1'b0;
        end else begin
            nop_loaded_q <= nop_loaded_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
